mips_mem_arbiter: RTL and testbench
===================================

# mips_mem_arbiter

Two-requester arbiter for the single-port unified memory of the multicycle MIPS core. It shares the memory between the core datapath port (instruction fetch and load/store, selected upstream by IorD) and a debug/loader port. It allows one outstanding transaction at a time, uses round-robin priority, and asserts a per-requester read-data valid after a fixed memory latency. The core control FSM holds its memory request until it sees its grant.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles, legal 1..4

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- core_req  in  1  core requests access; held until core_gnt
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  grant pulse; access issued this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  DATA_W  core read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port, same semantics as the core port
- dbg_gnt, dbg_rvalid  out  1  debug grant and read valid
- dbg_rdata  out  DATA_W  debug read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after the mem_en cycle

## Operation
- States:
  - IDLE: can grant.
  - RD_WAIT: read in flight; latency counter runs.
- IDLE:
  - Grant decision is combinational from core_req and dbg_req.
  - The granted port's gnt=1, mem_en=1. mem_we, mem_addr and mem_wdata are muxed from the granted port in the same cycle.
  - If no port is requesting, mem_en=0 and mem_addr/mem_wdata=0.
- Priority:
  - 1-bit `last` register records the last-granted port.
  - If both ports request, the port not in `last` wins.
  - If one port requests, it wins regardless of `last`.
  - `last` updates on every grant.
- Write grant: completes in the grant cycle; stay in IDLE.
- Read grant:
  - Load counter with MEM_LAT, record the owner, go to RD_WAIT.
  - In RD_WAIT, decrement the counter each cycle. When it reaches 0, assert the owner's rvalid for one cycle with rdata=mem_rdata, then return to IDLE.
- No grant is issued while in RD_WAIT. Requests are held externally and are never lost.
- rdata on the non-owner port, or when rvalid=0: 0.
- Starvation bound: a held request is granted no later than the second grant opportunity after it rises.

## Timing
- Reset values: every output 0, state IDLE, last=dbg (core wins the first tie), counter 0, any pending read discarded.
- rst asserted mid-read: no rvalid is produced. Grants resume the cycle after rst deasserts.
- Read granted at cycle t: rvalid at t+MEM_LAT. Earliest next grant at t+MEM_LAT+1.
- Write granted at t: next grant possible at t+1, so back-to-back writes run at 1 per cycle.
- Request inputs are sampled only in the gnt cycle. Dropping req before gnt withdraws it with no side effect.
- gnt is never asserted on both ports in the same cycle. rvalid is never asserted without a preceding read grant.

## Structure
- Package mips_mem_pkg holds:
  - state enum {IDLE, RD_WAIT}
  - requester ID constants REQ_CORE=0, REQ_DBG=1
  - MEM_LAT legality bound
- One natural sub-module: mips_rr_pick2, a combinational 2-way round-robin pick taking req[1:0] and last, producing a one-hot gnt. `last` stays in the parent.
- Counter width is $clog2(MEM_LAT+1).

## Test plan
- Core read of 0x40 alone, MEM_LAT=2, mem_rdata=0xDEADBEEF → core_gnt at t, core_rvalid at t+2 with core_rdata=0xDEADBEEF, dbg_rvalid=0 throughout.
- Both ports request reads together after reset → core granted first, dbg granted at t+MEM_LAT+1, then the next tie goes to core.
- Both ports hold continuous writes → grants alternate core, dbg, core, one per cycle, and mem_we=1 every cycle.
- dbg read in flight while core_req rises → core_gnt held off until the cycle after dbg_rvalid.
- rst pulsed one cycle after a core read grant (MEM_LAT=3) → no core_rvalid, all outputs 0, and the next core_req is granted the cycle after rst deasserts.
- core_req raised and dropped inside RD_WAIT → no core_gnt and no memory access issued.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS unified-memory arbiter.
// State encoding, requester IDs and the legal memory latency range.
package mips_mem_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/mips_mem_arbiter_pick2.sv
// Combinational 2-way round-robin pick: on a tie the port not named by last wins.
// Zero latency; emits a one-hot (or empty) grant vector.
module mips_rr_pick2
  import mips_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[REQ_CORE] && (!req[REQ_DBG] || (last == REQ_DBG))) begin
      gnt[REQ_CORE] = 1'b1;
    end else if (req[REQ_DBG]) begin
      gnt[REQ_DBG] = 1'b1;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter sharing single-port memory between core and debug ports.
// Writes complete in the grant cycle; reads return MEM_LAT cycles after grant, no grants meanwhile.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mips_mem_arbiter: MEM_LAT must be within 1..4");
  end

  state_t           state_q, state_d;
  logic             last_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0] pick;
  logic [1:0] gnt_v;
  logic       any_gnt;
  logic       sel_dbg;
  logic       gnt_we;
  logic       rd_done;

  mips_rr_pick2 u_pick (
    .req  ({dbg_req, core_req}),
    .last (last_q),
    .gnt  (pick)
  );

  // Outputs are forced quiet while rst is high, so grants resume the first cycle after it drops.
  assign gnt_v   = (state_q == IDLE && !rst) ? pick : 2'b00;
  assign any_gnt = |gnt_v;
  assign sel_dbg = gnt_v[REQ_DBG];
  assign gnt_we  = sel_dbg ? dbg_we : core_we;
  assign rd_done = (state_q == RD_WAIT) && (cnt_q == CNT_W'(1)) && !rst;

  assign core_gnt    = gnt_v[REQ_CORE];
  assign dbg_gnt     = gnt_v[REQ_DBG];
  assign core_rvalid = rd_done && (owner_q == REQ_CORE);
  assign dbg_rvalid  = rd_done && (owner_q == REQ_DBG);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign dbg_rdata   = dbg_rvalid  ? mem_rdata : '0;

  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (any_gnt) begin
      mem_en    = 1'b1;
      mem_we    = gnt_we;
      mem_addr  = sel_dbg ? dbg_addr  : core_addr;
      mem_wdata = sel_dbg ? dbg_wdata : core_wdata;
    end
    case (state_q)
      IDLE:    if (any_gnt && !gnt_we) state_d = RD_WAIT;
      RD_WAIT: if (cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= REQ_DBG;
      owner_q <= REQ_CORE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (any_gnt) begin
        last_q <= sel_dbg;
      end
      // Counter holds MEM_LAT on entry to RD_WAIT; data is returned in the cycle it would hit 0.
      if (any_gnt && !gnt_we) begin
        cnt_q   <= CNT_W'(MEM_LAT);
        owner_q <= sel_dbg;
      end else if (state_q == RD_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a small memory model and a read-return scoreboard.
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic        core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] core_rdata, dbg_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .dbg_req     (dbg_req),
    .dbg_we      (dbg_we),
    .dbg_addr    (dbg_addr),
    .dbg_wdata   (dbg_wdata),
    .dbg_gnt     (dbg_gnt),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  typedef struct {
    int          due;
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;
  logic [31:0] mem  [64];
  logic [31:0] pipe [LAT];

  function automatic logic [31:0] init_val(input int i);
    return (i == 16) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i));
  endfunction

  // Memory model: reloads on reset, returns read data LAT cycles after the access, junk otherwise.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:2]] : 32'hCAFEF00D;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic expect_rd(input logic port, input logic [31:0] data);
    sb.push_back('{due: cyc_n + LAT, port: port, data: data});
  endtask

  // One clock cycle: check grant/memory outputs and any read return due now.
  task automatic cyc(input logic cg, input logic dg, input logic en, input logic we,
                     input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    @(negedge clk);
    chk("core_gnt",  32'(core_gnt),  32'(cg));
    chk("dbg_gnt",   32'(dbg_gnt),   32'(dg));
    chk("mem_en",    32'(mem_en),    32'(en));
    chk("mem_we",    32'(mem_we),    32'(we));
    chk("mem_addr",  mem_addr,  addr);
    chk("mem_wdata", mem_wdata, wdata);
    if (sb.size() > 0 && sb[0].due == cyc_n) begin
      e = sb.pop_front();
      chk("core_rvalid", 32'(core_rvalid), 32'(e.port == REQ_CORE));
      chk("dbg_rvalid",  32'(dbg_rvalid),  32'(e.port == REQ_DBG));
      chk("core_rdata",  core_rdata, (e.port == REQ_CORE) ? e.data : 32'h0);
      chk("dbg_rdata",   dbg_rdata,  (e.port == REQ_DBG)  ? e.data : 32'h0);
    end else begin
      chk("core_rvalid_idle", 32'(core_rvalid), 32'h0);
      chk("dbg_rvalid_idle",  32'(dbg_rvalid),  32'h0);
      chk("core_rdata_idle",  core_rdata, 32'h0);
      chk("dbg_rdata_idle",   dbg_rdata,  32'h0);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic drive_core(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    core_req = req; core_we = we; core_addr = addr; core_wdata = wdata;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
  endtask

  initial begin
    rst = 1'b1;
    drive_core(1'b1, 1'b0, 32'h40, 32'h0);
    drive_dbg (1'b1, 1'b0, 32'h44, 32'h0);
    #1;
    // Reset: all outputs quiet even with both requests up.
    idle(2);
    rst = 1'b0;
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    drive_dbg (1'b0, 1'b0, 32'h0, 32'h0);
    idle(1);

    // Lone core read of 0x40.
    drive_core(1'b1, 1'b0, 32'h40, 32'h0);
    expect_rd(REQ_CORE, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    idle(LAT + 1);

    // Fresh reset, then tied reads: core first, dbg at t+LAT+1, next tie back to core.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    drive_core(1'b1, 1'b0, 32'h04, 32'h0);
    drive_dbg (1'b1, 1'b0, 32'h08, 32'h0);
    expect_rd(REQ_CORE, init_val(1));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h04, 32'h0);
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    idle(LAT);
    expect_rd(REQ_DBG, init_val(2));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h08, 32'h0);
    drive_core(1'b1, 1'b0, 32'h0C, 32'h0);
    drive_dbg (1'b1, 1'b0, 32'h10, 32'h0);
    idle(LAT);
    expect_rd(REQ_CORE, init_val(3));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0C, 32'h0);
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    idle(LAT);
    expect_rd(REQ_DBG, init_val(4));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    drive_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    idle(LAT);

    // Continuous writes from both ports alternate one per cycle.
    drive_core(1'b1, 1'b1, 32'h20, 32'hC0DE0001);
    drive_dbg (1'b1, 1'b1, 32'h24, 32'hDB600001);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'hC0DE0001);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h24, 32'hDB600001);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'hC0DE0001);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'h24, 32'hDB600001);
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    drive_dbg (1'b1, 1'b0, 32'h20, 32'h0);
    expect_rd(REQ_DBG, 32'hC0DE0001);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    drive_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    idle(LAT);

    // dbg read in flight holds off a rising core request until after dbg_rvalid.
    drive_dbg(1'b1, 1'b0, 32'h14, 32'h0);
    expect_rd(REQ_DBG, init_val(5));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
    drive_dbg (1'b0, 1'b0, 32'h0, 32'h0);
    drive_core(1'b1, 1'b0, 32'h24, 32'h0);
    idle(LAT);
    expect_rd(REQ_CORE, 32'hDB600001);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h24, 32'h0);
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    idle(LAT);

    // Reset one cycle after a core read grant discards it; next request granted right after.
    drive_core(1'b1, 1'b0, 32'h1C, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h1C, 32'h0);
    rst = 1'b1;
    drive_core(1'b1, 1'b0, 32'h18, 32'h0);
    idle(1);
    rst = 1'b0;
    expect_rd(REQ_CORE, init_val(6));
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h18, 32'h0);
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    idle(LAT);

    // A core request raised and dropped inside RD_WAIT leaves no trace.
    drive_dbg(1'b1, 1'b0, 32'h2C, 32'h0);
    expect_rd(REQ_DBG, init_val(11));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h2C, 32'h0);
    drive_dbg (1'b0, 1'b0, 32'h0, 32'h0);
    drive_core(1'b1, 1'b1, 32'h30, 32'h5555AAAA);
    idle(1);
    drive_core(1'b0, 1'b0, 32'h0, 32'h0);
    idle(LAT + 1);

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
